alif_array: RTL and testbench
=============================

# alif_array

Time-multiplexed array of adaptive leaky integrate-and-fire (ALIF) neurons, packaged as a Tiny Tapeout user project top. Generalises the single-neuron ALIF project to a parametrised neuron count and membrane width. Adds per-neuron adaptive thresholds, a refractory period and addressed or broadcast current injection. One shared update datapath serves all neurons round-robin; spike flags drive `uo_out`.

## Interface
Parameters:
- `NEURONS`, 4: neuron count; power of two, 2..8.
- `WIDTH`, 8: membrane and adaptation register width.
- `LEAK_SHIFT`, 3: membrane leak is `v >> LEAK_SHIFT` per update.
- `BASE_THR`, 128: threshold with zero adaptation.
- `ADAPT_INC`, 32: adaptation added on each spike.
- `ADAPT_SHIFT`, 3: adaptation decay shift.
- `REFRAC`, 2: refractory updates after a spike.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: design enable; state freezes while low.
- `ui_in` in 8: input current, unsigned.
- `uio_in` in 8: [2:0] target neuron index (low log2(NEURONS) bits used); [3] broadcast; [7:4] ignored.
- `uo_out` out 8: spike vector; bit n = neuron n; bits ≥ NEURONS tied 0.
- `uio_out` out 8: membrane probe (see Configuration), else 0.
- `uio_oe` out 8: 8'h00, or 8'hF0 with probe.

## Operation
- Pointer `p` (log2(NEURONS) bits) advances by 1 each cycle with `ena`=1 and wraps NEURONS-1 → 0. One sweep is NEURONS cycles and is one tick per neuron.
- Per-neuron state: membrane `v[WIDTH]`, adaptation `a[WIDTH]` and refractory count `r`, which is clog2(REFRAC+1) bits wide.
- Current `I` = `ui_in` if `uio_in[3]` or `uio_in[2:0]==p`, else 0; sampled in the slot of neuron p.
- Update of neuron p:
  - If `r>0`: `r--`; `v` held at 0; no integration; no spike.
  - Else: `vn = v - (v>>LEAK_SHIFT) + I`, computed in WIDTH+1 bits and saturated to 2^WIDTH-1.
  - Spike if `vn >= BASE_THR + a`, compared in WIDTH+1 bits with no overflow. On a spike: `v`←0, `a`←sat(a+ADAPT_INC), `r`←REFRAC.
  - Otherwise `v`←vn.
  - On every non-spike update, including refractory updates, with a>0: `a` ← a − max(a>>ADAPT_SHIFT, 1).
- `uo_out[p]` is registered to the spike result of the update and holds for one full sweep until neuron p's next slot.
- `ena`=0 freezes the pointer, all neuron state and all outputs.

## Timing
- Reset (async assert, sync release): all `v`, `a`, `r` = 0; `p`=0; `uo_out`=0; `uio_out`=0.
- Reset mid-sweep abandons the sweep; the first update after release is neuron 0.
- Latency: current sampled in slot p → `uo_out[p]` valid the next cycle.
- Changing `uio_in` or `ui_in` mid-sweep affects only later slots.

## Configuration
- `ALIF_MEMBRANE_PROBE_EN` defined: `uio_oe`=8'hF0. `uio_out[7:4]` = registered top 4 bits of `v[uio_in[2:0]]`, updated every enabled cycle. `uio_out[3:0]`=0.
- Not defined: `uio_oe`=8'h00, `uio_out`=8'h00, no probe logic.

## Structure
- Package `alif_pkg` holds:
  - default parameter constants;
  - the saturating add/sub functions;
  - the per-neuron state struct typedef.
- Sub-module `alif_update` is the combinational single-neuron update (v, a, r, I → v', a', r', spike). The top holds the state arrays, the pointer and the output registers.

## Test plan
All cases use default parameters.
- Reset: pulse `rst_n` low mid-sweep with `ui_in`=0 → `uo_out`=0, `uio_oe`=8'h00; no spikes over 4 sweeps.
- Addressed spike: `ui_in`=200, `uio_in`=0 → `uo_out`=8'h01 in the cycle after neuron 0's slot; bits 1–3 stay 0.
- Leak integration: `ui_in`=100 to neuron 1 for two sweeps → sweep 1 v=100, no spike; sweep 2 v=188 → `uo_out[1]`=1.
- Adaptation/refractory: broadcast `ui_in`=150 → spike sweep 1 (a=32); sweeps 2–3 refractory (a=28, 25); sweep 4 v=150 < 153, no spike; sweep 5 v saturates to 255 → spike, a=54.
- Freeze: `ena`=0 for 10 cycles mid-sweep → `p`, `uo_out` unchanged; resumes at the same neuron.
- Probe (macro on): 100 into neuron 2, `uio_in[2:0]`=2 → `uio_out`=8'h60, `uio_oe`=8'hF0.

Source files
------------

// File: rtl/alif_pkg.sv
// alif_pkg: shared constants, helpers and types for the ALIF neuron array.
//
// Contents:
//   - default geometry / dynamics constants used as parameter defaults
//   - cnt_w(): refractory counter width for a given refractory length
//   - sat_add() / sat_sub(): saturating arithmetic on 32-bit unsigned values
//   - alif_state_t: per-neuron state record at the default geometry
package alif_pkg;

  localparam int ALIF_NEURONS     = 4;
  localparam int ALIF_WIDTH       = 8;
  localparam int ALIF_LEAK_SHIFT  = 3;
  localparam int ALIF_BASE_THR    = 128;
  localparam int ALIF_ADAPT_INC   = 32;
  localparam int ALIF_ADAPT_SHIFT = 3;
  localparam int ALIF_REFRAC      = 2;

  // A zero refractory length still needs a 1-bit counter to keep the
  // state arrays legal.
  function automatic int cnt_w(input int refrac);
    return (refrac > 0) ? $clog2(refrac + 1) : 1;
  endfunction

  localparam int ALIF_RW = cnt_w(ALIF_REFRAC);

  // Operands are at most 16 bits wide in practice, so the 32-bit sum
  // cannot wrap before the clamp.
  function automatic int unsigned sat_add(input int unsigned x,
                                          input int unsigned y,
                                          input int unsigned lim);
    int unsigned s;
    s = x + y;
    return (s > lim) ? lim : s;
  endfunction

  function automatic int unsigned sat_sub(input int unsigned x,
                                          input int unsigned y);
    return (y >= x) ? 32'd0 : x - y;
  endfunction

  typedef struct packed {
    logic [ALIF_WIDTH-1:0] v;
    logic [ALIF_WIDTH-1:0] a;
    logic [ALIF_RW-1:0]    r;
  } alif_state_t;

endpackage

// File: rtl/alif_update.sv
// alif_update: combinational single-neuron ALIF update.
//
// Ports:
//   v, a, r     current membrane, adaptation and refractory count
//   cur         input current for this slot (already gated by addressing)
//   v_n, a_n,   next membrane, adaptation and refractory count
//   r_n
//   spike       1 when this update fires
module alif_update
  import alif_pkg::*;
#(
  parameter int WIDTH       = ALIF_WIDTH,
  parameter int LEAK_SHIFT  = ALIF_LEAK_SHIFT,
  parameter int BASE_THR    = ALIF_BASE_THR,
  parameter int ADAPT_INC   = ALIF_ADAPT_INC,
  parameter int ADAPT_SHIFT = ALIF_ADAPT_SHIFT,
  parameter int REFRAC      = ALIF_REFRAC,
  parameter int RW          = cnt_w(REFRAC)
) (
  input  logic [WIDTH-1:0] v,
  input  logic [WIDTH-1:0] a,
  input  logic [RW-1:0]    r,
  input  logic [7:0]       cur,
  output logic [WIDTH-1:0] v_n,
  output logic [WIDTH-1:0] a_n,
  output logic [RW-1:0]    r_n,
  output logic             spike
);

  localparam int unsigned V_MAX = (32'd1 << WIDTH) - 32'd1;

  int unsigned v_leak;
  int unsigned v_sum;
  int unsigned thr;
  int unsigned a_step;
  int unsigned a_dec;
  int unsigned a_inc;

  always_comb begin
    v_leak = 32'(v) - (32'(v) >> LEAK_SHIFT);
    v_sum  = sat_add(v_leak, 32'(cur), V_MAX);
    thr    = BASE_THR + 32'(a);

    // Decay step is at least 1 so small adaptation values still reach 0;
    // sat_sub keeps a==0 pinned at 0.
    a_step = 32'(a) >> ADAPT_SHIFT;
    if (a_step == 32'd0) a_step = 32'd1;
    a_dec  = sat_sub(32'(a), a_step);
    a_inc  = sat_add(32'(a), ADAPT_INC, V_MAX);

    v_n   = v;
    a_n   = a;
    r_n   = r;
    spike = 1'b0;

    if (r != '0) begin
      v_n = '0;
      r_n = r - RW'(1);
      a_n = WIDTH'(a_dec);
    end else if (v_sum >= thr) begin
      spike = 1'b1;
      v_n   = '0;
      a_n   = WIDTH'(a_inc);
      r_n   = RW'(REFRAC);
    end else begin
      v_n = WIDTH'(v_sum);
      a_n = WIDTH'(a_dec);
    end
  end

endmodule

// File: rtl/alif_array.sv
// alif_array: time-multiplexed array of adaptive leaky integrate-and-fire
// neurons (Tiny Tapeout user project top). One alif_update instance serves
// all neurons round-robin, one neuron per enabled cycle.
//
// Ports:
//   clk      clock
//   rst_n    asynchronous active-low reset
//   ena      enable; pointer, neuron state and outputs freeze while low
//   ui_in    input current (unsigned)
//   uio_in   [2:0] target neuron, [3] broadcast, [7:4] ignored
//   uo_out   spike vector, bit n = neuron n, upper bits 0
//   uio_out  membrane probe in [7:4] when enabled, else 0
//   uio_oe   8'hF0 with probe, else 8'h00
//
// Build option: define ALIF_MEMBRANE_PROBE_EN to expose the top 4 bits of
// the membrane of neuron uio_in[2:0] on uio_out[7:4].
module alif_array
  import alif_pkg::*;
#(
  parameter int NEURONS     = ALIF_NEURONS,
  parameter int WIDTH       = ALIF_WIDTH,
  parameter int LEAK_SHIFT  = ALIF_LEAK_SHIFT,
  parameter int BASE_THR    = ALIF_BASE_THR,
  parameter int ADAPT_INC   = ALIF_ADAPT_INC,
  parameter int ADAPT_SHIFT = ALIF_ADAPT_SHIFT,
  parameter int REFRAC      = ALIF_REFRAC
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int PW = $clog2(NEURONS);
  localparam int RW = cnt_w(REFRAC);

  logic [PW-1:0]      p;
  logic [WIDTH-1:0]   v_q [NEURONS];
  logic [WIDTH-1:0]   a_q [NEURONS];
  logic [RW-1:0]      r_q [NEURONS];
  logic [NEURONS-1:0] spk_q;

  logic               hit;
  logic [7:0]         cur;
  logic [WIDTH-1:0]   v_n;
  logic [WIDTH-1:0]   a_n;
  logic [RW-1:0]      r_n;
  logic               spike;

  assign hit = uio_in[3] | (uio_in[PW-1:0] == p);
  assign cur = hit ? ui_in : 8'd0;

  alif_update #(
    .WIDTH      (WIDTH),
    .LEAK_SHIFT (LEAK_SHIFT),
    .BASE_THR   (BASE_THR),
    .ADAPT_INC  (ADAPT_INC),
    .ADAPT_SHIFT(ADAPT_SHIFT),
    .REFRAC     (REFRAC),
    .RW         (RW)
  ) u_update (
    .v    (v_q[p]),
    .a    (a_q[p]),
    .r    (r_q[p]),
    .cur  (cur),
    .v_n  (v_n),
    .a_n  (a_n),
    .r_n  (r_n),
    .spike(spike)
  );

  // NEURONS is a power of two, so the pointer wraps on its own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p     <= '0;
      spk_q <= '0;
      for (int n = 0; n < NEURONS; n++) begin
        v_q[n] <= '0;
        a_q[n] <= '0;
        r_q[n] <= '0;
      end
    end else if (ena) begin
      p        <= p + PW'(1);
      v_q[p]   <= v_n;
      a_q[p]   <= a_n;
      r_q[p]   <= r_n;
      spk_q[p] <= spike;
    end
  end

  assign uo_out = 8'(spk_q);

`ifdef ALIF_MEMBRANE_PROBE_EN
  logic [3:0] probe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      probe_q <= '0;
    end else if (ena) begin
      probe_q <= v_q[uio_in[PW-1:0]][WIDTH-1 -: 4];
    end
  end

  assign uio_out = {probe_q, 4'h0};
  assign uio_oe  = 8'hF0;
`else
  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;
`endif

  // Upper uio_in bits (and, for small arrays, unused index bits) are
  // don't-care inputs.
  logic unused_in;
  assign unused_in = &{1'b0, uio_in};

endmodule

// File: tb/tb_alif_array.sv
`timescale 1ns/1ps
module tb_alif_array;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  wire  [7:0] uo_out;
  wire  [7:0] uio_out;
  wire  [7:0] uio_oe;

  alif_array dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

`ifdef ALIF_MEMBRANE_PROBE_EN
  localparam logic [7:0] EXP_OE = 8'hF0;
`else
  localparam logic [7:0] EXP_OE = 8'h00;
`endif

  typedef struct {
    string      name;
    logic [7:0] uo;
    logic [3:0] probe;
    bit         chk_probe;
  } exp_t;

  exp_t       sb_q[$];
  int         checks   = 0;
  int         failures = 0;
  logic [7:0] exp_uo   = 8'h00;
  int         tb_p     = 0;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %02h expected %02h", nm, act, req);
    end
  endtask

  // One clock of stimulus; the expected outputs after the following rising
  // edge are queued for the monitor.
  task automatic step(input string nm, input logic r, input logic en,
                      input logic [7:0] ui, input logic [7:0] uio,
                      input logic spk, input logic [3:0] prb = 4'h0,
                      input bit chk = 1'b0);
    exp_t e;
    @(negedge clk);
    rst_n  = r;
    ena    = en;
    ui_in  = ui;
    uio_in = uio;
    if (!r) begin
      exp_uo = 8'h00;
      tb_p   = 0;
    end else if (en) begin
      exp_uo[tb_p] = spk;
      tb_p = (tb_p + 1) % 4;
    end
    e.name = nm;
    e.uo = exp_uo;
    e.probe = prb;
    e.chk_probe = chk;
    sb_q.push_back(e);
  endtask

  // spk[i] is the expected spike of neuron i in this sweep.
  task automatic sweep(input string nm, input logic [7:0] ui,
                       input logic [7:0] uio, input logic [3:0] spk);
    for (int i = 0; i < 4; i++) step(nm, 1'b1, 1'b1, ui, uio, spk[i]);
  endtask

  task automatic do_reset();
    step("reset", 1'b0, 1'b1, 8'd0, 8'd0, 1'b0);
    step("reset", 1'b0, 1'b1, 8'd0, 8'd0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        cmp({e.name, "/uo_out"}, uo_out, e.uo);
        cmp({e.name, "/uio_oe"}, uio_oe, EXP_OE);
`ifdef ALIF_MEMBRANE_PROBE_EN
        if (e.chk_probe) cmp({e.name, "/probe"}, uio_out, {e.probe, 4'h0});
`else
        cmp({e.name, "/uio_out"}, uio_out, 8'h00);
`endif
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    rst_n  = 1'b0;
    ena    = 1'b1;
    ui_in  = 8'd0;
    uio_in = 8'd0;

    do_reset();
    for (int s = 0; s < 4; s++) sweep("idle", 8'd0, 8'h00, 4'b0000);

    // Load neuron 2, then reset partway through the sweep.
    for (int i = 0; i < 3; i++) step("pre_rst", 1'b1, 1'b1, 8'd100, 8'h02, 1'b0);
    do_reset();
    // First slot after release must be neuron 0; upper uio_in bits ignored.
    sweep("addr_spike", 8'd200, 8'hF4, 4'b0001);
    // Neuron 2 was cleared: 100 alone stays below threshold; neuron 0 refractory.
    sweep("rst_clear", 8'd100, 8'h02, 4'b0000);

    do_reset();
    sweep("leak1", 8'd100, 8'h01, 4'b0000);
    sweep("leak2", 8'd100, 8'h01, 4'b0010);
    sweep("leak3", 8'd0, 8'h00, 4'b0000);

    do_reset();
    sweep("adapt1", 8'd150, 8'h08, 4'b1111);
    sweep("adapt2", 8'd150, 8'hF8, 4'b0000);
    sweep("adapt3", 8'd150, 8'h08, 4'b0000);
    sweep("adapt4", 8'd150, 8'h08, 4'b0000);
    sweep("adapt5", 8'd150, 8'h08, 4'b1111);
    sweep("adapt6", 8'd150, 8'h08, 4'b0000);

    do_reset();
    step("frz_a", 1'b1, 1'b1, 8'd200, 8'h00, 1'b1);
    step("frz_b", 1'b1, 1'b1, 8'd200, 8'h01, 1'b1);
    for (int i = 0; i < 10; i++) step("frozen", 1'b1, 1'b0, 8'd200, 8'h08, 1'b0);
    step("frz_c", 1'b1, 1'b1, 8'd200, 8'h02, 1'b1);
    step("frz_d", 1'b1, 1'b1, 8'd0, 8'h00, 1'b0);
    step("frz_e", 1'b1, 1'b1, 8'd0, 8'h00, 1'b0);

    // Probe follows v[2] one enabled cycle late: 100 -> 0x6, leaked 88 -> 0x5.
    do_reset();
    step("probe0", 1'b1, 1'b1, 8'd100, 8'h02, 1'b0, 4'h0, 1'b1);
    step("probe1", 1'b1, 1'b1, 8'd100, 8'h02, 1'b0, 4'h0, 1'b1);
    step("probe2", 1'b1, 1'b1, 8'd100, 8'h02, 1'b0, 4'h0, 1'b1);
    step("probe3", 1'b1, 1'b1, 8'd100, 8'h02, 1'b0, 4'h6, 1'b1);
    step("probe4", 1'b1, 1'b1, 8'd0, 8'h02, 1'b0, 4'h6, 1'b1);
    step("probe5", 1'b1, 1'b1, 8'd0, 8'h02, 1'b0, 4'h6, 1'b1);
    step("probe6", 1'b1, 1'b1, 8'd0, 8'h02, 1'b0, 4'h6, 1'b1);
    step("probe7", 1'b1, 1'b1, 8'd0, 8'h02, 1'b0, 4'h5, 1'b1);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
